// File: rtl/stochastic_addsub_array_if.sv
// Handshake and data bundle for the stochastic add/sub array: the stream and control
// inputs, together with the registered y stream, per-channel counts and status.
interface stochastic_addsub_array_if #(
  parameter int CHANNELS = 4,
  parameter int WIN_LOG2 = 8
);
  logic                               start;
  logic [CHANNELS-1:0]                mode;
  logic                               en;
  logic [CHANNELS-1:0]                a;
  logic [CHANNELS-1:0]                b;
  logic [CHANNELS-1:0]                y;
  logic                               y_vld;
  logic [CHANNELS*(WIN_LOG2+1)-1:0]   count;
  logic                               busy;
  logic                               done;

  modport master (
    output start, mode, en, a, b,
    input  y, y_vld, count, busy, done
  );

  modport slave (
    input  start, mode, en, a, b,
    output y, y_vld, count, busy, done
  );
endinterface

// File: rtl/stochastic_addsub_array.sv
// Multi-channel windowed stochastic adder/subtractor: one shared LFSR picks a or b (or ~b)
// per channel, and each channel counts its output ones over 2**WIN_LOG2 enabled bits.
module stochastic_addsub_array #(
  parameter int          CHANNELS = 4,
  parameter int          LFSR_W   = 8,
  parameter int unsigned SEED     = 32'hA5,
  parameter int          WIN_LOG2 = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  stochastic_addsub_array_if.slave bus
);
  localparam int CW = WIN_LOG2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Tap sets: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1.
  localparam int TAP_A = (LFSR_W == 16) ? 15 : 7;
  localparam int TAP_B = (LFSR_W == 16) ? 13 : 5;
  localparam int TAP_C = (LFSR_W == 16) ? 12 : 4;
  localparam int TAP_D = (LFSR_W == 16) ? 10 : 3;

  localparam logic [LFSR_W-1:0] SEED_W   = LFSR_W'(SEED);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED_W == '0) ? LFSR_W'(1) : SEED_W;

  logic [1:0]             state_q, state_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic [WIN_LOG2-1:0]    bitcnt_q, bitcnt_d;
  logic [CHANNELS-1:0]    mode_q, mode_d;
  logic [CHANNELS-1:0]    y_q, y_d;
  logic                   y_vld_q, y_vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CHANNELS*CW-1:0] count_q, count_d;
  logic                   sel;
  logic                   fb;
  logic                   ybit;

  assign sel = lfsr_q[0];
  assign fb  = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    bitcnt_d = bitcnt_q;
    mode_d   = mode_q;
    y_d      = y_q;
    y_vld_d  = 1'b0;
    count_d  = count_q;
    ybit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lfsr_d   = SEED_EFF;
          count_d  = '0;
          bitcnt_d = '0;
          mode_d   = bus.mode;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.en) begin
          for (int i = 0; i < CHANNELS; i++) begin
            // Subtract is add with the complemented B stream: (A + (1-B)) / 2.
            ybit = sel ? bus.a[i] : (mode_q[i] ^ bus.b[i]);
            y_d[i] = ybit;
            count_d[i*CW +: CW] = count_q[i*CW +: CW] + CW'(ybit);
          end
          y_vld_d  = 1'b1;
          lfsr_d   = {lfsr_q[LFSR_W-2:0], fb};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == '1) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      bitcnt_q <= '0;
      mode_q   <= '0;
      y_q      <= '0;
      y_vld_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      bitcnt_q <= bitcnt_d;
      mode_q   <= mode_d;
      y_q      <= y_d;
      y_vld_q  <= y_vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.y_vld = y_vld_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
